// File: rtl/dt_pkg.sv
`default_nettype none
// dt_pkg: geometry, widths and sequencing states shared by the distance-transform
// engine and its result read-back streamer.
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/res_fifo2.sv
`default_nettype none
// res_fifo2: two-entry FIFO that absorbs result-RAM read data ahead of the stream.
// The caller must never push into a full FIFO unless it pops in the same cycle.
module res_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              pop_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/res_stream_out.sv
`default_nettype none
// res_stream_out: reads the finished result image out of the result RAM in address
// order onto a valid/ready stream, tracking the frame maximum and non-zero count.
module res_stream_out #(
  parameter int ADDR_W = dt_pkg::ADDR_W,
  parameter int DATA_W = dt_pkg::DATA_W,
  parameter int NPIX   = dt_pkg::NPIX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_di,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W:0]   nz_cnt
);

  import dt_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] out_ptr_q;
  logic [DATA_W-1:0] max_q;
  logic [ADDR_W:0]   nz_q;

  logic [DATA_W-1:0] head;
  logic [1:0]        fifo_cnt;
  logic [1:0]        occ_d;
  logic              hs;

  // A read driven this cycle lands in the FIFO at the next edge, so it is
  // already counted there through the push.
  res_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (rd_q),
    .data_i  (res_di),
    .pop_i   (hs),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != 2'd0);
  assign hs        = out_valid && out_ready;
  assign out_data  = head;
  assign out_last  = out_valid && (out_ptr_q == LAST_ADDR);
  assign occ_d     = fifo_cnt + 2'(rd_q) - 2'(hs);

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign max_val  = max_q;
  assign nz_cnt   = nz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      rd_ptr_q  <= '0;
      out_ptr_q <= '0;
      max_q     <= '0;
      nz_q      <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;

      if (hs) begin
        out_ptr_q <= out_ptr_q + 1'b1;
        if (head > max_q) begin
          max_q <= head;
        end
        nz_q <= nz_q + (ADDR_W+1)'(head != '0);
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= (NPIX == 1) ? DRAIN : RUN;
            busy_q    <= 1'b1;
            rd_q      <= 1'b1;
            addr_q    <= '0;
            rd_ptr_q  <= ADDR_W'(1);
            out_ptr_q <= '0;
            max_q     <= '0;
            nz_q      <= '0;
          end
        end
        RUN: begin
          if (occ_d < 2'd2) begin
            rd_q   <= 1'b1;
            addr_q <= rd_ptr_q;
            if (rd_ptr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs && out_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_res_stream_out.sv
`default_nettype none
// tb_res_stream_out: scoreboard bench; frames queue their expected pixels, and a
// negedge monitor pops and compares each predicted stream handshake.
module tb_res_stream_out;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NPIX   = 16384;

  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic              start     = 1'b0;
  logic              busy;
  logic              done;
  logic              res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di    = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [DATA_W-1:0] max_val;
  logic [ADDR_W:0]   nz_cnt;

  logic [DATA_W-1:0] mem [NPIX];
  logic [8:0]        exp_q [$];
  logic [ADDR_W-1:0] rd_log [$];
  int                n_pass    = 0;
  int                n_total   = 0;
  int                hs_cnt    = 0;
  logic              rdy_mode  = 1'b0;
  logic              rdy_force = 1'b1;

  res_stream_out #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NPIX   (NPIX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .max_val   (max_val),
    .nz_cnt    (nz_cnt)
  );

  always #5 clk = ~clk;

  // Result RAM: read completes on the falling edge.
  always @(negedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
  endtask

  // Monitor: ready only changes just after posedge, so valid&&ready seen here
  // is the handshake of the coming edge.
  logic       done_pend  = 1'b0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      done_pend  = 1'b0;
      stall_pend = 1'b0;
    end else begin
      chk("done_pulse", 32'(done), 32'(done_pend));
      if (done_pend) chk("busy_at_done", 32'(busy), 32'd0);
      if (stall_pend) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (res_rd) rd_log.push_back(res_addr);
      done_pend = 1'b0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pixel: got data %0h with no pixel expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", 32'(out_data), 32'(e[7:0]));
          chk("pixel_last", 32'(out_last), 32'(e[8]));
        end
        done_pend = out_last;
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_res_rd"},    32'(res_rd),    0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_res_addr"},  32'(res_addr),  0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_max_val"},   32'(max_val),   0);
    chk({tag, "_nz_cnt"},    32'(nz_cnt),    0);
  endtask

  task automatic run_frame(input int restart_at, input int stall, input int reset_at,
                           input int limit, input logic [7:0] exp_max, input int exp_nz,
                           output int ncyc);
    int   base_hs = hs_cnt;
    int   base_rd = rd_log.size();
    bit   pulsed  = 0;
    bit   got_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_res_rd",   32'(res_rd),    1);
    chk("start_res_addr", 32'(res_addr),  0);
    chk("start_busy",     32'(busy),      1);
    chk("start_valid",    32'(out_valid), 0);
    chk("start_max_clr",  32'(max_val),   0);
    chk("start_nz_clr",   32'(nz_cnt),    0);
    ncyc = 0;
    while (ncyc < limit) begin
      @(posedge clk);
      #1;
      ncyc++;
      start = 1'b0;
      if (ncyc == 1) chk("first_valid", 32'(out_valid), 1);
      if (stall > 0 && ncyc == stall) begin
        chk("stall_reads", rd_log.size() - base_rd, 2);
        chk("stall_addr0", 32'(rd_log[base_rd]), 0);
        chk("stall_addr1", 32'(rd_log[base_rd+1]), 1);
        chk("stall_rd_low", 32'(res_rd), 0);
        chk("stall_hs", hs_cnt - base_hs, 0);
        rdy_force = 1'b1;
      end
      if (restart_at >= 0 && !pulsed && (hs_cnt - base_hs) >= restart_at) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (reset_at >= 0 && (hs_cnt - base_hs) >= reset_at) begin
        if (stall > 0)
          chk("resume_addr", (rd_log.size() > base_rd + 2) ? 32'(rd_log[base_rd+2]) : 32'hFFFF, 2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        return;
      end
      if (done) begin
        got_done = 1;
        break;
      end
    end
    if (!got_done) begin
      chk("frame_done", 32'(done), 1);
      return;
    end
    chk("frame_pixels",    hs_cnt - base_hs, NPIX);
    chk("frame_queue",     exp_q.size(), 0);
    chk("frame_max",       32'(max_val), 32'(exp_max));
    chk("frame_nz",        32'(nz_cnt), exp_nz);
    chk("frame_reads",     rd_log.size() - base_rd, NPIX);
    chk("frame_last_addr", 32'(rd_log[rd_log.size()-1]), NPIX - 1);
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back({(i == NPIX - 1), mem[i]});
  endtask

  initial begin
    int ncyc;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Ramp image, ready high, stray start at pixel 3000.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    push_frame();
    run_frame(3000, 0, -1, NPIX + 100, 8'hFF, NPIX - 64, ncyc);
    chk("ramp_latency", ncyc, NPIX + 1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_max",  32'(max_val), 32'hFF);
    chk("hold_nz",   32'(nz_cnt),  NPIX - 64);
    chk("hold_busy", 32'(busy),    0);
    chk("hold_rd",   32'(res_rd),  0);

    // Ramp image, sink stalled 100 cycles, reset at pixel 8000.
    rdy_force = 1'b0;
    @(posedge clk);
    push_frame();
    run_frame(-1, 100, 8000, NPIX + 300, 8'hFF, NPIX - 64, ncyc);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // All-zero image after reset.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    push_frame();
    run_frame(-1, 0, -1, NPIX + 100, 8'h00, 0, ncyc);
    chk("zero_latency", ncyc, NPIX + 1);

    // Single 0x2A pixel at 5000, random sink ready.
    mem[5000] = 8'h2A;
    push_frame();
    rdy_mode = 1'b1;
    run_frame(-1, 0, -1, 4 * NPIX + 100, 8'h2A, 1, ncyc);
    rdy_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
